zbt_frame_arbiter: RTL and testbench

- Shares the single-port ZBT frame memory among three requesters:
  - the VGA pixel fetch (read, real-time),
  - the NTSC capture writer,
  - an auxiliary read/write port used by the projective-transform stage.
- Owns double-buffer bank selection:
  - VGA always reads the display bank; NTSC always writes the other bank.
  - Banks swap at a frame boundary only once a full capture frame has completed.
- Sits between the VGA writer/NTSC capture blocks and the ZBT pad interface.

---
 rtl/zbt_frame_arbiter_pkg.sv | 20 ++
 rtl/zbt_frame_arbiter_if.sv | 45 ++++
 rtl/zbt_frame_arbiter_rd_pipe.sv | 31 +++
 rtl/zbt_frame_arbiter.sv | 104 ++++++++++
 tb/tb_zbt_frame_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zbt_frame_arbiter_pkg.sv
// Shared constants and types for the ZBT frame-memory arbiter.
// Requester IDs and the read-return tag carried through the latency pipe.
package zbt_frame_arbiter_pkg;

    localparam int LOG_MEM    = 36;
    localparam int LOG_ADDR   = 19;
    localparam int MEM_RD_LAT = 2;

    typedef enum logic [1:0] {
        REQ_VGA  = 2'd0,
        REQ_NTSC = 2'd1,
        REQ_AUX  = 2'd2
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/zbt_frame_arbiter_if.sv
// Requester and ZBT pad signals of the frame arbiter.
// slave = arbiter side, master = requesters plus memory.
interface zbt_frame_arbiter_if
    import zbt_frame_arbiter_pkg::*;
#(
    parameter int LOG_MEM  = zbt_frame_arbiter_pkg::LOG_MEM,
    parameter int LOG_ADDR = zbt_frame_arbiter_pkg::LOG_ADDR
);
    logic                frame_flag;
    logic                vga_flag;
    logic [LOG_ADDR-2:0] vga_addr;
    logic                done_vga;
    logic [LOG_MEM-1:0]  vga_pixel;
    logic                ntsc_flag;
    logic [LOG_ADDR-2:0] ntsc_addr;
    logic [LOG_MEM-1:0]  ntsc_data;
    logic                ntsc_frame_done;
    logic                done_ntsc;
    logic                aux_flag;
    logic                aux_we;
    logic [LOG_ADDR-1:0] aux_addr;
    logic [LOG_MEM-1:0]  aux_wdata;
    logic                done_aux;
    logic [LOG_MEM-1:0]  aux_rdata;
    logic                display_bank;
    logic [LOG_ADDR-1:0] mem_addr;
    logic                mem_we;
    logic [LOG_MEM-1:0]  mem_wdata;
    logic [LOG_MEM-1:0]  mem_rdata;

    modport slave (
        input  frame_flag, vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
               ntsc_frame_done, aux_flag, aux_we, aux_addr, aux_wdata, mem_rdata,
        output done_vga, vga_pixel, done_ntsc, done_aux, aux_rdata, display_bank,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output frame_flag, vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
               ntsc_frame_done, aux_flag, aux_we, aux_addr, aux_wdata, mem_rdata,
        input  done_vga, vga_pixel, done_ntsc, done_aux, aux_rdata, display_bank,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/zbt_frame_arbiter_rd_pipe.sv
// RD_LAT-deep shift register of read tags; out_tag is the tag whose data
// is on mem_rdata this cycle.
module zbt_rd_pipe
    import zbt_frame_arbiter_pkg::*;
#(
    parameter int RD_LAT = MEM_RD_LAT
) (
    input  logic clock,
    input  logic reset,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t stage [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_tag = stage[RD_LAT-1];

endmodule

// File: rtl/zbt_frame_arbiter.sv
// Fixed-priority (vga > ntsc > aux) arbiter for the single-port ZBT frame
// memory, with double-buffer bank selection swapped at frame boundaries.
module zbt_frame_arbiter
    import zbt_frame_arbiter_pkg::*;
#(
    parameter int LOG_MEM  = zbt_frame_arbiter_pkg::LOG_MEM,
    parameter int LOG_ADDR = zbt_frame_arbiter_pkg::LOG_ADDR,
    parameter int RD_LAT   = MEM_RD_LAT
) (
    input logic                  clock,
    input logic                  reset,
    zbt_frame_arbiter_if.slave   bus
);

    // Per-requester vectors, bit 0 = vga, 1 = ntsc, 2 = aux.
    logic [2:0] flags, live, busy, done, grant, wr_ret, rd_ret, complete;
    logic       grant_read, exit_vga, exit_aux;
    tag_t       pipe_in, pipe_out;

    logic [LOG_ADDR-1:0] addr_q;
    logic                we_q;
    logic [LOG_MEM-1:0]  wdata_q, vga_pixel_q, aux_rdata_q;
    logic                bank_q, swap_pending;

    assign flags    = {bus.aux_flag, bus.ntsc_flag, bus.vga_flag};
    assign live     = flags & ~done & ~busy;
    assign complete = wr_ret | rd_ret;

    always_comb begin
        grant = '0;
        if (live[0])      grant = 3'b001;
        else if (live[1]) grant = 3'b010;
        else if (live[2]) grant = 3'b100;
        grant_read    = grant[0] | (grant[2] & ~bus.aux_we);
        pipe_in.valid = grant_read;
        pipe_in.id    = grant[2] ? REQ_AUX : REQ_VGA;
        exit_vga      = pipe_out.valid && (pipe_out.id == REQ_VGA);
        exit_aux      = pipe_out.valid && (pipe_out.id == REQ_AUX);
    end

    zbt_rd_pipe #(.RD_LAT(RD_LAT)) rd_pipe (
        .clock   (clock),
        .reset   (reset),
        .in_tag  (pipe_in),
        .out_tag (pipe_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            busy         <= '0;
            done         <= '0;
            wr_ret       <= '0;
            rd_ret       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            vga_pixel_q  <= '0;
            aux_rdata_q  <= '0;
            bank_q       <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (grant[0]) begin
                addr_q <= {bank_q, bus.vga_addr};
            end else if (grant[1]) begin
                addr_q  <= {~bank_q, bus.ntsc_addr};
                we_q    <= 1'b1;
                wdata_q <= bus.ntsc_data;
            end else if (grant[2]) begin
                addr_q <= bus.aux_addr;
                we_q   <= bus.aux_we;
                if (bus.aux_we) wdata_q <= bus.aux_wdata;
            end

            if (exit_vga) vga_pixel_q <= bus.mem_rdata;
            if (exit_aux) aux_rdata_q <= bus.mem_rdata;

            // Completion is registered one edge after write issue / read capture;
            // done is only raised if the requester is still holding its flag.
            wr_ret <= grant & {bus.aux_we, 1'b1, 1'b0};
            rd_ret <= {exit_aux, 1'b0, exit_vga};
            busy   <= (busy | grant) & ~complete;
            done   <= flags & (done | complete);

            if (bus.frame_flag && (swap_pending || bus.ntsc_frame_done)) begin
                bank_q       <= ~bank_q;
                swap_pending <= 1'b0;
            end else if (bus.ntsc_frame_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign bus.done_vga     = done[0];
    assign bus.done_ntsc    = done[1];
    assign bus.done_aux     = done[2];
    assign bus.vga_pixel    = vga_pixel_q;
    assign bus.aux_rdata    = aux_rdata_q;
    assign bus.display_bank = bank_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_wdata    = wdata_q;

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Self-checking bench for zbt_frame_arbiter: behavioural ZBT model,
// issue/read-data scoreboards and one task per scenario.
module tb_zbt_frame_arbiter;

    localparam int LM = 36;
    localparam int LA = 19;

    typedef struct {
        logic [LA-1:0] addr;
        logic          we;
        logic [LM-1:0] wdata;
    } issue_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    issue_t        exp_issue[$];
    logic [LM-1:0] exp_vga[$];
    logic [LM-1:0] exp_aux[$];
    logic [LM-1:0] zmem [logic [LA-1:0]];

    zbt_frame_arbiter_if #(.LOG_MEM(LM), .LOG_ADDR(LA)) bus ();

    zbt_frame_arbiter #(.LOG_MEM(LM), .LOG_ADDR(LA), .RD_LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [LM-1:0] lookup(input logic [LA-1:0] a);
        return zmem.exists(a) ? zmem[a] : {17'd0, a};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ZBT model for RD_LAT = 2: the address presented in one cycle returns
    // its data in the following cycle; writes land at the end of their cycle.
    always @(posedge clock) begin
        logic [LA-1:0] a;
        logic          w;
        logic [LM-1:0] wd;
        a  = bus.mem_addr;
        w  = bus.mem_we;
        wd = bus.mem_wdata;
        #1;
        if (w === 1'b1) zmem[a] = wd;
        else if (^a !== 1'bx) bus.mem_rdata = lookup(a);
    end

    // Read-data scoreboard: each rising done pops the expected held data.
    logic prev_vga = 1'b0, prev_aux = 1'b0;
    always @(posedge clock) begin
        logic [LM-1:0] e;
        #2;
        if (bus.done_vga === 1'b1 && !prev_vga) begin
            checks++;
            if (exp_vga.size() == 0) begin
                errors++;
                $display("FAIL vga_done_unexpected: got done_vga=1 expected 0");
            end else begin
                e = exp_vga.pop_front();
                if (bus.vga_pixel !== e) begin
                    errors++;
                    $display("FAIL vga_pixel: got %h expected %h", bus.vga_pixel, e);
                end
            end
        end
        if (bus.done_aux === 1'b1 && !prev_aux) begin
            checks++;
            if (exp_aux.size() == 0) begin
                errors++;
                $display("FAIL aux_done_unexpected: got done_aux=1 expected 0");
            end else begin
                e = exp_aux.pop_front();
                if (bus.aux_rdata !== e) begin
                    errors++;
                    $display("FAIL aux_rdata: got %h expected %h", bus.aux_rdata, e);
                end
            end
        end
        prev_vga = bus.done_vga;
        prev_aux = bus.done_aux;
    end

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({bus.done_vga, bus.done_ntsc, bus.done_aux, bus.mem_we, bus.display_bank} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.done_vga, bus.done_ntsc, bus.done_aux, bus.mem_we, bus.display_bank});
        end
        checks++;
        if ({bus.vga_pixel, bus.aux_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     bus.vga_pixel, bus.aux_rdata, bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_vga_read();
        int we_count = 0;
        zmem[19'h00100] = 36'hA5A5A5A5A;
        exp_vga.push_back(36'hA5A5A5A5A);
        bus.vga_addr = 18'h00100;
        bus.vga_flag = 1'b1;
        tick(1);
        checks++;
        if (bus.mem_addr !== 19'h00100 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL vga_issue: got addr=%h we=%b expected addr=00100 we=0", bus.mem_addr, bus.mem_we);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.done_vga !== (k == 3 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL vga_latency_k%0d: got done_vga=%b expected 0", k, bus.done_vga);
            end
            tick(1);
        end
        checks++;
        if (bus.done_vga !== 1'b1) begin
            errors++;
            $display("FAIL vga_done: got %b expected 1", bus.done_vga);
        end
        // A second read would now pick up different data.
        zmem[19'h00100] = 36'h0DEADBEEF;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (bus.mem_we === 1'b1) we_count++;
        end
        checks++;
        if (bus.vga_pixel !== 36'hA5A5A5A5A || we_count != 0 || bus.done_vga !== 1'b1) begin
            errors++;
            $display("FAIL vga_hold_single_access: got pixel=%h writes=%0d done=%b expected A5A5A5A5A 0 1",
                     bus.vga_pixel, we_count, bus.done_vga);
        end
        bus.vga_flag = 1'b0;
        tick(1);
        checks++;
        if (bus.done_vga !== 1'b0) begin
            errors++;
            $display("FAIL vga_done_drop: got %b expected 0", bus.done_vga);
        end
    endtask

    task automatic test_ntsc_write();
        int we_count = 0;
        bus.ntsc_addr = 18'h00010;
        bus.ntsc_data = 36'h123456789;
        bus.ntsc_flag = 1'b1;
        tick(1);
        checks++;
        if (bus.mem_addr !== 19'h40010 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 36'h123456789
            || bus.done_ntsc !== 1'b0) begin
            errors++;
            $display("FAIL ntsc_issue: got addr=%h we=%b wdata=%h done=%b expected 40010 1 123456789 0",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.done_ntsc);
        end
        tick(1);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.done_ntsc !== 1'b1) begin
            errors++;
            $display("FAIL ntsc_done: got we=%b done=%b expected we=0 done=1", bus.mem_we, bus.done_ntsc);
        end
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (bus.mem_we === 1'b1) we_count++;
        end
        checks++;
        if (we_count != 0 || bus.done_ntsc !== 1'b1) begin
            errors++;
            $display("FAIL ntsc_hold: got writes=%0d done=%b expected 0 1", we_count, bus.done_ntsc);
        end
        bus.ntsc_flag = 1'b0;
        tick(1);
        checks++;
        if (bus.done_ntsc !== 1'b0) begin
            errors++;
            $display("FAIL ntsc_done_drop: got %b expected 0", bus.done_ntsc);
        end
    endtask

    task automatic test_priority();
        issue_t e;
        logic [2:0] d, x;
        exp_issue.push_back('{addr: 19'h00200, we: 1'b0, wdata: '0});
        exp_issue.push_back('{addr: 19'h40020, we: 1'b1, wdata: 36'h0BEEF0001});
        exp_issue.push_back('{addr: 19'h12345, we: 1'b0, wdata: '0});
        exp_vga.push_back(lookup(19'h00200));
        exp_aux.push_back(lookup(19'h12345));
        bus.vga_addr  = 18'h00200;
        bus.ntsc_addr = 18'h00020;
        bus.ntsc_data = 36'h0BEEF0001;
        bus.aux_addr  = 19'h12345;
        bus.aux_we    = 1'b0;
        {bus.vga_flag, bus.ntsc_flag, bus.aux_flag} = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (k < 3) begin
                e = exp_issue.pop_front();
                checks++;
                if (bus.mem_addr !== e.addr || bus.mem_we !== e.we || (e.we && bus.mem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL prio_issue_%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                             k, bus.mem_addr, bus.mem_we, bus.mem_wdata, e.addr, e.we, e.wdata);
                end
            end
            x = {k >= 5, k >= 2, k >= 3};
            d = {bus.done_aux, bus.done_ntsc, bus.done_vga};
            checks++;
            if (d !== x) begin
                errors++;
                $display("FAIL prio_done_%0d: got aux/ntsc/vga=%b expected %b", k, d, x);
            end
        end
        {bus.vga_flag, bus.ntsc_flag, bus.aux_flag} = 3'b000;
        tick(1);
        checks++;
        if ({bus.done_aux, bus.done_ntsc, bus.done_vga} !== 3'b000) begin
            errors++;
            $display("FAIL prio_done_drop: got %b expected 000", {bus.done_aux, bus.done_ntsc, bus.done_vga});
        end
    endtask

    task automatic test_bank_swap();
        bus.ntsc_frame_done = 1'b1;
        tick(1);
        bus.ntsc_frame_done = 1'b0;
        tick(9);
        checks++;
        if (bus.display_bank !== 1'b0) begin
            errors++;
            $display("FAIL bank_before_frame: got %b expected 0", bus.display_bank);
        end
        bus.frame_flag = 1'b1;
        tick(1);
        bus.frame_flag = 1'b0;
        checks++;
        if (bus.display_bank !== 1'b1) begin
            errors++;
            $display("FAIL bank_swap: got %b expected 1", bus.display_bank);
        end
        tick(2);
        bus.frame_flag = 1'b1;
        tick(1);
        bus.frame_flag = 1'b0;
        checks++;
        if (bus.display_bank !== 1'b1) begin
            errors++;
            $display("FAIL bank_no_pending: got %b expected 1", bus.display_bank);
        end
        exp_vga.push_back(lookup(19'h40005));
        bus.vga_addr = 18'h00005;
        bus.vga_flag = 1'b1;
        tick(1);
        checks++;
        if (bus.mem_addr !== 19'h40005) begin
            errors++;
            $display("FAIL bank1_vga_addr: got %h expected 40005", bus.mem_addr);
        end
        tick(3);
        bus.vga_flag = 1'b0;
        tick(1);
        bus.ntsc_frame_done = 1'b1;
        bus.frame_flag      = 1'b1;
        tick(1);
        bus.ntsc_frame_done = 1'b0;
        bus.frame_flag      = 1'b0;
        tick(1);
        bus.frame_flag = 1'b1;
        tick(1);
        bus.frame_flag = 1'b0;
        checks++;
        if (bus.display_bank !== 1'b0) begin
            errors++;
            $display("FAIL bank_simultaneous: got %b expected 0", bus.display_bank);
        end
    endtask

    task automatic test_aux_read();
        zmem[19'h7FFFF] = 36'hFFFFFFFFF;
        exp_aux.push_back(36'hFFFFFFFFF);
        bus.aux_addr = 19'h7FFFF;
        bus.aux_we   = 1'b0;
        bus.aux_flag = 1'b1;
        tick(1);
        checks++;
        if (bus.mem_addr !== 19'h7FFFF || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL aux_rd_issue: got addr=%h we=%b expected 7ffff 0", bus.mem_addr, bus.mem_we);
        end
        tick(2);
        checks++;
        if (bus.done_aux !== 1'b0) begin
            errors++;
            $display("FAIL aux_rd_early: got %b expected 0", bus.done_aux);
        end
        tick(1);
        checks++;
        if (bus.done_aux !== 1'b1 || bus.aux_rdata !== 36'hFFFFFFFFF) begin
            errors++;
            $display("FAIL aux_rd_done: got done=%b data=%h expected 1 fffffffff", bus.done_aux, bus.aux_rdata);
        end
        bus.aux_flag = 1'b0;
        tick(1);
    endtask

    task automatic test_aux_write();
        exp_aux.push_back(36'hFFFFFFFFF);
        bus.aux_addr  = 19'h00055;
        bus.aux_wdata = 36'h0CAFEF00D;
        bus.aux_we    = 1'b1;
        bus.aux_flag  = 1'b1;
        tick(1);
        checks++;
        if (bus.mem_addr !== 19'h00055 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 36'h0CAFEF00D) begin
            errors++;
            $display("FAIL aux_wr_issue: got addr=%h we=%b wdata=%h expected 00055 1 0cafef00d",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        tick(1);
        checks++;
        if (bus.done_aux !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL aux_wr_done: got done=%b we=%b expected 1 0", bus.done_aux, bus.mem_we);
        end
        bus.aux_flag = 1'b0;
        bus.aux_we   = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_midread();
        int done_seen = 0;
        bus.aux_addr = 19'h00ABC;
        bus.aux_we   = 1'b0;
        bus.aux_flag = 1'b1;
        tick(1);
        reset        = 1'b1;
        bus.aux_flag = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.done_aux !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0 || bus.aux_rdata !== '0) begin
            errors++;
            $display("FAIL reset_midread: got done_cycles=%0d aux_rdata=%h expected 0 0", done_seen, bus.aux_rdata);
        end
    endtask

    initial begin
        {bus.frame_flag, bus.vga_flag, bus.ntsc_flag, bus.ntsc_frame_done, bus.aux_flag, bus.aux_we} = '0;
        bus.vga_addr  = '0;
        bus.ntsc_addr = '0;
        bus.ntsc_data = '0;
        bus.aux_addr  = '0;
        bus.aux_wdata = '0;
        bus.mem_rdata = '0;
        test_reset();
        test_vga_read();
        test_ntsc_write();
        test_priority();
        test_bank_swap();
        test_aux_read();
        test_aux_write();
        test_reset_midread();
        tick(2);
        checks++;
        if (exp_vga.size() != 0 || exp_aux.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding: got vga=%0d aux=%0d expected 0 0", exp_vga.size(), exp_aux.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
